// File: rtl/sdhci_cmd_sched_pkg.sv
// Shared types and constants for the SD CMD-line scheduler.
package sdhci_cmd_sched_pkg;

    typedef enum logic [1:0] {
        RSP_NONE    = 2'd0,
        RSP_136     = 2'd1,
        RSP_48      = 2'd2,
        RSP_48_BUSY = 2'd3
    } rsp_type_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_TX,
        WAIT_RSP,
        BUSY_DLY,
        WAIT_BUSY,
        DONE
    } state_e;

    localparam logic [5:0]  CMD12_INDEX = 6'd12;
    localparam logic [31:0] CMD12_ARG   = 32'h0;

    // Larger of two integers, used to size the shared tick counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdhci_tick_timer.sv
// Saturating tick counter with synchronous clear and a runtime compare limit.
// o_hit flags the enabled tick on which the count reaches (or sits at) the limit.
module sdhci_tick_timer #(
    parameter int Width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [Width-1:0] i_limit,
    output logic             o_hit
);

    logic [Width-1:0] r_count;
    logic [Width-1:0] w_count_inc;

    assign w_count_inc = (r_count == {Width{1'b1}}) ? r_count : r_count + 1'b1;
    assign o_hit       = i_en && (w_count_inc >= i_limit);

    // Count enabled ticks; clear wins over counting and the value never wraps.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/sdhci_cmd_scheduler.sv
// SD CMD-line scheduler: arbitrates software commands against auto-CMD12,
// latches the winner, starts the command engine and tracks transmit,
// response and R1b busy phases with tick-based timeouts.
module sdhci_cmd_scheduler
    import sdhci_cmd_sched_pkg::*;
#(
    parameter int RspTimeoutTicks  = 64,
    parameter int BusyTimeoutTicks = 1_000_000,
    parameter int BusyStartTicks   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_p_i,
    input  logic        abort_i,
    input  logic        sw_cmd_valid_i,
    output logic        sw_cmd_ready_o,
    input  logic [5:0]  sw_cmd_index_i,
    input  logic [31:0] sw_cmd_arg_i,
    input  logic [1:0]  sw_rsp_type_i,
    input  logic        acmd12_req_i,
    output logic        acmd12_ack_o,
    output logic        cmd_start_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic [1:0]  cmd_rsp_type_o,
    input  logic        cmd_done_i,
    input  logic        rsp_done_i,
    input  logic        dat0_i,
    output logic        inhibit_cmd_o,
    output logic        acmd12_active_o,
    output logic        cmd_complete_o,
    output logic        acmd12_done_o,
    output logic        rsp_timeout_o,
    output logic        busy_timeout_o
);

    localparam int CntW = $clog2(max_int(RspTimeoutTicks, BusyTimeoutTicks) + 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [5:0]  r_index;
    logic [31:0] r_arg;
    rsp_type_e   r_rsp_type;
    logic        r_acmd12_active;

    logic            w_kill;
    logic            w_acmd12_accept;
    logic            w_sw_accept;
    logic            w_rsp_to;
    logic            w_busy_to;
    logic            w_tmr_run;
    logic            w_tmr_clr;
    logic            w_tmr_hit;
    logic [CntW-1:0] w_tmr_limit;

    // Reset and abort suppress every pulse and handshake in the cycle they occur.
    assign w_kill          = rst_i || abort_i;
    assign w_acmd12_accept = (r_state == IDLE) && acmd12_req_i;
    assign w_sw_accept     = (r_state == IDLE) && !acmd12_req_i && sw_cmd_valid_i;

    assign w_tmr_run = (r_state == WAIT_RSP) || (r_state == BUSY_DLY) || (r_state == WAIT_BUSY);
    // Each counting phase starts from zero because any state change clears the timer.
    assign w_tmr_clr = !w_tmr_run || (w_state_nxt != r_state) || abort_i;

    // Select the limit that applies to the current counting phase.
    always_comb begin
        w_tmr_limit = CntW'(RspTimeoutTicks);
        case (r_state)
            BUSY_DLY:  w_tmr_limit = CntW'(BusyStartTicks);
            WAIT_BUSY: w_tmr_limit = CntW'(BusyTimeoutTicks);
            default:   w_tmr_limit = CntW'(RspTimeoutTicks);
        endcase
    end

    sdhci_tick_timer #(
        .Width (CntW)
    ) u_tick_timer (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clr   (w_tmr_clr),
        .i_en    (clk_en_p_i && w_tmr_run),
        .i_limit (w_tmr_limit),
        .o_hit   (w_tmr_hit)
    );

    // Next-state and timeout decisions; abort overrides everything.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        w_state_nxt = r_state;
        w_rsp_to    = 1'b0;
        w_busy_to   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acmd12_accept || w_sw_accept) w_state_nxt = ISSUE;
            end
            ISSUE: w_state_nxt = WAIT_TX;
            WAIT_TX: begin
                if (cmd_done_i) w_state_nxt = (r_rsp_type == RSP_NONE) ? DONE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_done_i) begin
                    w_state_nxt = (r_rsp_type == RSP_48_BUSY) ? BUSY_DLY : DONE;
                end else if (w_tmr_hit) begin
                    w_state_nxt = IDLE;
                    w_rsp_to    = 1'b1;
                end
            end
            BUSY_DLY: begin
                if (w_tmr_hit) w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (clk_en_p_i && dat0_i) begin
                    w_state_nxt = DONE;
                end else if (w_tmr_hit) begin
                    w_state_nxt = IDLE;
                    w_busy_to   = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (abort_i) begin
            w_state_nxt = IDLE;
            w_rsp_to    = 1'b0;
            w_busy_to   = 1'b0;
        end
    end

    // State register and command latch; fields hold from accept until reset or abort.
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            r_state         <= IDLE;
            r_index         <= '0;
            r_arg           <= '0;
            r_rsp_type      <= RSP_NONE;
            r_acmd12_active <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acmd12_accept) begin
                r_index         <= CMD12_INDEX;
                r_arg           <= CMD12_ARG;
                r_rsp_type      <= RSP_48_BUSY;
                r_acmd12_active <= 1'b1;
            end else if (w_sw_accept) begin
                r_index    <= sw_cmd_index_i;
                r_arg      <= sw_cmd_arg_i;
                r_rsp_type <= rsp_type_e'(sw_rsp_type_i);
            end else if (w_state_nxt == IDLE) begin
                r_acmd12_active <= 1'b0;
            end
        end
    end

    assign sw_cmd_ready_o  = (r_state == IDLE) && !acmd12_req_i && !w_kill;
    assign acmd12_ack_o    = w_acmd12_accept && !w_kill;
    assign cmd_start_o     = (r_state == ISSUE) && !w_kill;
    assign cmd_complete_o  = (r_state == DONE) && !r_acmd12_active && !w_kill;
    assign acmd12_done_o   = (r_state == DONE) && r_acmd12_active && !w_kill;
    assign rsp_timeout_o   = w_rsp_to && !rst_i;
    assign busy_timeout_o  = w_busy_to && !rst_i;
    assign inhibit_cmd_o   = (r_state != IDLE);
    assign acmd12_active_o = r_acmd12_active;
    assign cmd_index_o     = r_index;
    assign cmd_arg_o       = r_arg;
    assign cmd_rsp_type_o  = r_rsp_type;

endmodule

// File: tb/tb_sdhci_cmd_scheduler.sv
// Directed bench for sdhci_cmd_scheduler. Inputs change 2 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_sdhci_cmd_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clk_en_p_i;
    logic        abort_i;
    logic        sw_cmd_valid_i;
    logic        sw_cmd_ready_o;
    logic [5:0]  sw_cmd_index_i;
    logic [31:0] sw_cmd_arg_i;
    logic [1:0]  sw_rsp_type_i;
    logic        acmd12_req_i;
    logic        acmd12_ack_o;
    logic        cmd_start_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic [1:0]  cmd_rsp_type_o;
    logic        cmd_done_i;
    logic        rsp_done_i;
    logic        dat0_i;
    logic        inhibit_cmd_o;
    logic        acmd12_active_o;
    logic        cmd_complete_o;
    logic        acmd12_done_o;
    logic        rsp_timeout_o;
    logic        busy_timeout_o;

    logic [5:0]  pulses;
    logic [48:0] all_out;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    sdhci_cmd_scheduler #(
        .RspTimeoutTicks  (64),
        .BusyTimeoutTicks (50),
        .BusyStartTicks   (2)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clk_en_p_i      (clk_en_p_i),
        .abort_i         (abort_i),
        .sw_cmd_valid_i  (sw_cmd_valid_i),
        .sw_cmd_ready_o  (sw_cmd_ready_o),
        .sw_cmd_index_i  (sw_cmd_index_i),
        .sw_cmd_arg_i    (sw_cmd_arg_i),
        .sw_rsp_type_i   (sw_rsp_type_i),
        .acmd12_req_i    (acmd12_req_i),
        .acmd12_ack_o    (acmd12_ack_o),
        .cmd_start_o     (cmd_start_o),
        .cmd_index_o     (cmd_index_o),
        .cmd_arg_o       (cmd_arg_o),
        .cmd_rsp_type_o  (cmd_rsp_type_o),
        .cmd_done_i      (cmd_done_i),
        .rsp_done_i      (rsp_done_i),
        .dat0_i          (dat0_i),
        .inhibit_cmd_o   (inhibit_cmd_o),
        .acmd12_active_o (acmd12_active_o),
        .cmd_complete_o  (cmd_complete_o),
        .acmd12_done_o   (acmd12_done_o),
        .rsp_timeout_o   (rsp_timeout_o),
        .busy_timeout_o  (busy_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    assign pulses  = {acmd12_ack_o, cmd_start_o, cmd_complete_o, acmd12_done_o,
                      rsp_timeout_o, busy_timeout_o};
    assign all_out = {sw_cmd_ready_o, acmd12_ack_o, cmd_start_o, cmd_index_o, cmd_arg_o,
                      cmd_rsp_type_o, inhibit_cmd_o, acmd12_active_o, cmd_complete_o,
                      acmd12_done_o, rsp_timeout_o, busy_timeout_o};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    // Accept cycle then ISSUE cycle; leaves the bench in the ISSUE cycle.
    task automatic sw_issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
        next_cycle();
        sw_cmd_valid_i = 1'b1;
        sw_cmd_index_i = idx;
        sw_cmd_arg_i   = arg;
        sw_rsp_type_i  = typ;
        settle();
        check("accept_ready", sw_cmd_ready_o, 1'b1);
        next_cycle();
        sw_cmd_valid_i = 1'b0;
        settle();
        check("issue_start", {cmd_start_o, inhibit_cmd_o, cmd_index_o, cmd_arg_o, cmd_rsp_type_o},
              {1'b1, 1'b1, idx, arg, typ});
    endtask

    // One WAIT_TX cycle with cmd_done_i asserted.
    task automatic tx_done();
        next_cycle();
        cmd_done_i = 1'b1;
        settle();
        check("wait_tx_no_pulse", pulses, 6'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        clk_en_p_i = 1'b0;
        abort_i = 1'b0;
        sw_cmd_valid_i = 1'b0;
        sw_cmd_index_i = '0;
        sw_cmd_arg_i = '0;
        sw_rsp_type_i = '0;
        acmd12_req_i = 1'b0;
        cmd_done_i = 1'b0;
        rsp_done_i = 1'b0;
        dat0_i = 1'b1;

        // Reset state
        next_cycle();
        next_cycle();
        settle();
        check("reset_all_zero", all_out, 49'h0);
        next_cycle();
        rst_i = 1'b0;
        settle();
        check("post_reset_idle", all_out, {1'b1, 48'h0});

        // Test 1: software R48, ticks every other cycle, rsp_done after 10 ticks
        sw_issue(6'd8, 32'h1AA, 2'd2);
        next_cycle();
        settle();
        check("t1_start_once", {cmd_start_o, inhibit_cmd_o}, 2'b01);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            settle();
            check("t1_tx_inhibit", inhibit_cmd_o, 1'b1);
        end
        tx_done();
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            cmd_done_i = 1'b0;
            clk_en_p_i = (i % 2 == 0);
            settle();
            check("t1_wait_rsp", {inhibit_cmd_o, pulses, cmd_index_o, cmd_arg_o},
                  {1'b1, 6'b0, 6'd8, 32'h1AA});
        end
        next_cycle();
        clk_en_p_i = 1'b0;
        rsp_done_i = 1'b1;
        settle();
        check("t1_rsp_cycle", cmd_complete_o, 1'b0);
        next_cycle();
        rsp_done_i = 1'b0;
        settle();
        check("t1_complete", {cmd_complete_o, acmd12_done_o, inhibit_cmd_o}, 3'b101);
        next_cycle();
        settle();
        check("t1_back_idle", {cmd_complete_o, inhibit_cmd_o, cmd_index_o}, {2'b00, 6'd8});

        // Test 2: response timeout on the 64th tick after cmd_done_i
        sw_issue(6'd17, 32'h55, 2'd2);
        tx_done();
        for (int i = 1; i <= 64; i++) begin
            next_cycle();
            cmd_done_i = 1'b0;
            clk_en_p_i = 1'b1;
            settle();
            check("t2_rsp_timeout", {rsp_timeout_o, cmd_complete_o, inhibit_cmd_o},
                  {(i == 64), 1'b0, 1'b1});
        end
        next_cycle();
        clk_en_p_i = 1'b0;
        settle();
        check("t2_idle_no_complete", {inhibit_cmd_o, pulses}, 7'b0);

        // Test 3: auto CMD12 and software request rise together
        next_cycle();
        acmd12_req_i = 1'b1;
        sw_cmd_valid_i = 1'b1;
        sw_cmd_index_i = 6'd25;
        sw_cmd_arg_i = 32'hDEADBEEF;
        sw_rsp_type_i = 2'd2;
        settle();
        check("t3_arb", {acmd12_ack_o, sw_cmd_ready_o}, 2'b10);
        next_cycle();
        acmd12_req_i = 1'b0;
        settle();
        check("t3_cmd12_latched",
              {cmd_start_o, acmd12_active_o, sw_cmd_ready_o, cmd_index_o, cmd_arg_o, cmd_rsp_type_o},
              {3'b110, 6'd12, 32'h0, 2'd3});
        tx_done();
        next_cycle();
        cmd_done_i = 1'b0;
        rsp_done_i = 1'b1;
        settle();
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            rsp_done_i = 1'b0;
            clk_en_p_i = 1'b1;
            settle();
            check("t3_busy_delay", {acmd12_done_o, inhibit_cmd_o}, 2'b01);
        end
        next_cycle();
        settle();
        check("t3_acmd12_done", {acmd12_done_o, cmd_complete_o}, 2'b10);
        next_cycle();
        settle();
        check("t3_sw_accept", {sw_cmd_ready_o, acmd12_active_o, inhibit_cmd_o}, 3'b100);
        next_cycle();
        sw_cmd_valid_i = 1'b0;
        settle();
        check("t3_sw_issue", {cmd_start_o, cmd_index_o, cmd_arg_o}, {1'b1, 6'd25, 32'hDEADBEEF});

        // Test 5: abort in WAIT_RSP coinciding with rsp_done_i
        tx_done();
        next_cycle();
        cmd_done_i = 1'b0;
        clk_en_p_i = 1'b0;
        settle();
        check("t5_in_wait_rsp", inhibit_cmd_o, 1'b1);
        next_cycle();
        abort_i = 1'b1;
        rsp_done_i = 1'b1;
        settle();
        check("t5_abort_no_pulse", pulses, 6'b0);
        next_cycle();
        abort_i = 1'b0;
        rsp_done_i = 1'b0;
        settle();
        check("t5_idle_after_abort", all_out, {1'b1, 48'h0});

        // Test 4a: R1b, DAT0 low for 40 busy ticks, then released
        clk_en_p_i = 1'b1;
        sw_issue(6'd7, 32'h1234, 2'd3);
        tx_done();
        next_cycle();
        cmd_done_i = 1'b0;
        rsp_done_i = 1'b1;
        settle();
        for (int k = 1; k <= 43; k++) begin
            next_cycle();
            rsp_done_i = 1'b0;
            dat0_i = (k == 43);
            settle();
            check("t4_busy_hold", {cmd_complete_o, busy_timeout_o, inhibit_cmd_o}, 3'b001);
        end
        next_cycle();
        settle();
        check("t4_release_complete", {cmd_complete_o, busy_timeout_o}, 2'b10);
        next_cycle();
        settle();
        check("t4_release_idle", inhibit_cmd_o, 1'b0);

        // Test 4b: DAT0 held low, busy timeout after 50 ticks
        sw_issue(6'd7, 32'h1234, 2'd3);
        tx_done();
        next_cycle();
        cmd_done_i = 1'b0;
        rsp_done_i = 1'b1;
        settle();
        for (int k = 1; k <= 52; k++) begin
            next_cycle();
            rsp_done_i = 1'b0;
            dat0_i = 1'b0;
            settle();
            check("t4_busy_timeout", {busy_timeout_o, cmd_complete_o, inhibit_cmd_o},
                  {(k == 52), 1'b0, 1'b1});
        end
        next_cycle();
        settle();
        check("t4_timeout_idle", {inhibit_cmd_o, pulses}, 7'b0);

        // Test 6: reset in WAIT_BUSY, then a new command right after release
        sw_issue(6'd40, 32'hCAFE, 2'd3);
        tx_done();
        next_cycle();
        cmd_done_i = 1'b0;
        rsp_done_i = 1'b1;
        settle();
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            rsp_done_i = 1'b0;
            settle();
        end
        check("t6_in_wait_busy", {inhibit_cmd_o, cmd_index_o}, {1'b1, 6'd40});
        next_cycle();
        rst_i = 1'b1;
        settle();
        check("t6_reset_no_pulse", {pulses, sw_cmd_ready_o}, 7'b0);
        next_cycle();
        settle();
        check("t6_reset_all_zero", all_out, 49'h0);
        next_cycle();
        rst_i = 1'b0;
        dat0_i = 1'b1;
        settle();
        sw_issue(6'd3, 32'h0, 2'd0);
        tx_done();
        next_cycle();
        cmd_done_i = 1'b0;
        settle();
        check("t6_none_complete", {cmd_complete_o, inhibit_cmd_o}, 2'b11);
        next_cycle();
        settle();
        check("t6_final_idle", {inhibit_cmd_o, pulses}, 7'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
